// File: rtl/video_pkg.sv
// Shared types and defaults for the video frame buffer.
package video_pkg;

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_WRITING,
        BANK_FULL,
        BANK_DISPLAY
    } bank_state_t;

    localparam int DEF_SRC_W = 200;
    localparam int DEF_SRC_H = 150;
    localparam int DEF_SCALE = 4;

    // Read path depth: RAM read register, then output register.
    localparam int RD_STAGES = 2;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/framebuf_bank.sv
// One frame bank: SRC_W*SRC_H pixels, synchronous write, registered read.
module framebuf_bank #(
    parameter int  DEPTH = 30000,
    parameter int  BPP   = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [BPP-1:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [BPP-1:0] rdata
);

    logic [BPP-1:0] mem [DEPTH];

    // Write port and registered read port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/video_framebuf.sv
// Multi-bank video frame buffer: writer fills banks in order, the VGA side
// displays the oldest complete bank from each frame_tick, scaled by SCALE.
// Optional: define VIDEO_FRAMEBUF_DROP_OLDEST_EN to recycle the oldest
// complete frame instead of stalling the writer when no bank is free.
module video_framebuf
    import video_pkg::*;
#(
    parameter int  NUM_BANKS = 2,
    parameter int  BPP       = 1,
    parameter int  SCALE     = DEF_SCALE,
    parameter int  SRC_W     = DEF_SRC_W,
    parameter int  SRC_H     = DEF_SRC_H,
    localparam int BW        = $clog2(NUM_BANKS)
) (
    input  logic           CLK_40,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [BPP-1:0] in_data,
    input  logic           in_sof,
    input  logic           frame_tick,
    input  logic           active,
    input  logic [10:0]    VGA_x_pos,
    input  logic [9:0]     VGA_y_pos,
    output logic [BPP-1:0] pix_out,
    output logic           pix_valid,
    output logic [BW-1:0]  rd_bank,
    output logic [BW-1:0]  wr_bank,
    output logic [15:0]    frames_repeated,
    output logic [15:0]    frames_dropped
);

    localparam int DEPTH = SRC_W * SRC_H;
    localparam int AW    = $clog2(DEPTH);
    localparam int XW    = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int YW    = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int SH    = $clog2(SCALE);

    if (!is_pow2(SCALE)) begin : g_bad_scale
        $error("video_framebuf: SCALE must be a power of 2");
    end
    if (NUM_BANKS < 2 || NUM_BANKS > 4) begin : g_bad_banks
        $error("video_framebuf: NUM_BANKS must be 2..4");
    end

    // Bank bookkeeping. The FULL list never exceeds NUM_BANKS-1 entries,
    // so a BW-bit count is enough.
    bank_state_t   st   [NUM_BANKS];
    bank_state_t   st_n [NUM_BANKS];
    logic [BW-1:0] fq   [NUM_BANKS];
    logic [BW-1:0] fq_n [NUM_BANKS];
    logic [BW-1:0] fcnt, fcnt_n, rd_n, wr_n, alloc_idx;
    logic          has_wr, has_wr_n, alloc;
    logic [XW-1:0] wx, wx_n, ax;
    logic [YW-1:0] wy, wy_n, ay;
    logic [15:0]   rep_n;
    logic          accept, done;
    logic [AW-1:0] waddr;
`ifdef VIDEO_FRAMEBUF_DROP_OLDEST_EN
    logic [15:0]   drop_n;
`endif

    // A start-of-frame beat restarts the raster at the origin.
    assign accept   = in_valid && has_wr;
    assign ax       = in_sof ? '0 : wx;
    assign ay       = in_sof ? '0 : wy;
    assign done     = accept && (ax == XW'(SRC_W - 1)) && (ay == YW'(SRC_H - 1));
    assign waddr    = AW'(32'(ay) * SRC_W + 32'(ax));
    assign in_ready = has_wr;

    // Next bank state: completion first, then tick (so a just-finished
    // frame can be shown at once), then allocation from what is left FREE.
    always_comb begin
        st_n      = st;
        fq_n      = fq;
        fcnt_n    = fcnt;
        rd_n      = rd_bank;
        wr_n      = wr_bank;
        has_wr_n  = has_wr;
        wx_n      = wx;
        wy_n      = wy;
        rep_n     = frames_repeated;
        alloc     = 1'b0;
        alloc_idx = '0;
`ifdef VIDEO_FRAMEBUF_DROP_OLDEST_EN
        drop_n    = frames_dropped;
`endif
        if (accept) begin
            if (done) begin
                wx_n           = '0;
                wy_n           = '0;
                st_n[wr_bank]  = BANK_FULL;
                fq_n[fcnt]     = wr_bank;
                fcnt_n         = fcnt + 1'b1;
                has_wr_n       = 1'b0;
            end else if (ax == XW'(SRC_W - 1)) begin
                wx_n = '0;
                wy_n = ay + 1'b1;
            end else begin
                wx_n = ax + 1'b1;
                wy_n = ay;
            end
        end
        if (frame_tick) begin
            if (fcnt_n != '0) begin
                st_n[rd_bank] = BANK_FREE;
                st_n[fq_n[0]] = BANK_DISPLAY;
                rd_n          = fq_n[0];
                for (int i = 0; i < NUM_BANKS - 1; i++) fq_n[i] = fq_n[i+1];
                fcnt_n        = fcnt_n - 1'b1;
            end else if (rep_n != 16'hFFFF) begin
                rep_n = rep_n + 1'b1;
            end
        end
        if (!has_wr_n) begin
            for (int i = NUM_BANKS - 1; i >= 0; i--) begin
                if (st_n[i] == BANK_FREE) begin
                    alloc     = 1'b1;
                    alloc_idx = BW'(i);
                end
            end
            if (alloc) begin
                st_n[alloc_idx] = BANK_WRITING;
                wr_n            = alloc_idx;
                has_wr_n        = 1'b1;
            end
`ifdef VIDEO_FRAMEBUF_DROP_OLDEST_EN
            else if (done && fcnt_n != '0) begin
                st_n[fq_n[0]] = BANK_WRITING;
                wr_n          = fq_n[0];
                has_wr_n      = 1'b1;
                for (int i = 0; i < NUM_BANKS - 1; i++) fq_n[i] = fq_n[i+1];
                fcnt_n        = fcnt_n - 1'b1;
                if (drop_n != 16'hFFFF) drop_n = drop_n + 1'b1;
            end
`endif
        end
    end

    // Bank state registers; reset shows bank 0 and writes bank 1.
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                st[i] <= (i == 0) ? BANK_DISPLAY : (i == 1) ? BANK_WRITING : BANK_FREE;
                fq[i] <= '0;
            end
            fcnt            <= '0;
            rd_bank         <= '0;
            wr_bank         <= BW'(1);
            has_wr          <= 1'b1;
            wx              <= '0;
            wy              <= '0;
            frames_repeated <= '0;
        end else begin
            st              <= st_n;
            fq              <= fq_n;
            fcnt            <= fcnt_n;
            rd_bank         <= rd_n;
            wr_bank         <= wr_n;
            has_wr          <= has_wr_n;
            wx              <= wx_n;
            wy              <= wy_n;
            frames_repeated <= rep_n;
        end
    end

`ifdef VIDEO_FRAMEBUF_DROP_OLDEST_EN
    // Saturating count of complete frames recycled unseen.
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) frames_dropped <= '0;
        else       frames_dropped <= drop_n;
    end
`else
    assign frames_dropped = '0;
`endif

    // Read side: scaled raster position, shared by all banks.
    logic [10:0]                    sx;
    logic [9:0]                     sy;
    logic                           in_range;
    logic [AW-1:0]                  raddr;
    logic [NUM_BANKS-1:0][BPP-1:0]  bank_rdata;
    logic [RD_STAGES:1]             vld_pipe;
    logic [RD_STAGES-1:1]           ok_pipe;
    logic [BW-1:0]                  rd_sel;

    assign sx       = VGA_x_pos >> SH;
    assign sy       = VGA_y_pos >> SH;
    assign in_range = (32'(VGA_x_pos) < SRC_W * SCALE) && (32'(VGA_y_pos) < SRC_H * SCALE);
    assign raddr    = in_range ? AW'(32'(sy) * SRC_W + 32'(sx)) : '0;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        framebuf_bank #(.DEPTH(DEPTH), .BPP(BPP)) u_bank (
            .clk   (CLK_40),
            .we    (accept && (wr_bank == BW'(b))),
            .waddr (waddr),
            .wdata (in_data),
            .raddr (raddr),
            .rdata (bank_rdata[b])
        );
    end

    // Align valid, blanking and bank choice with the RAM read register.
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            ok_pipe  <= '0;
            rd_sel   <= '0;
            pix_out  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_STAGES-1:1], active};
            ok_pipe  <= active && in_range;
            rd_sel   <= rd_bank;
            pix_out  <= ok_pipe[RD_STAGES-1] ? bank_rdata[rd_sel] : '0;
        end
    end

    assign pix_valid = vld_pipe[RD_STAGES];

endmodule

// File: tb/tb_video_framebuf.sv
// Directed bench for video_framebuf (default 2 banks, 200x150, SCALE 4).
// With VIDEO_FRAMEBUF_DROP_OLDEST_EN a second small 3-bank instance
// exercises frame dropping.
module tb_video_framebuf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_sof = 1'b0, frame_tick = 1'b0, active = 1'b0;
    logic [0:0]  in_data = '0;
    logic [10:0] vx = '0;
    logic [9:0]  vy = '0;
    logic        in_ready, pix_valid;
    logic [0:0]  pix_out, rd_bank, wr_bank;
    logic [15:0] reps, drops;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    video_framebuf dut (
        .CLK_40(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof), .frame_tick(frame_tick), .active(active),
        .VGA_x_pos(vx), .VGA_y_pos(vy), .pix_out(pix_out), .pix_valid(pix_valid),
        .rd_bank(rd_bank), .wr_bank(wr_bank), .frames_repeated(reps), .frames_dropped(drops)
    );

`ifdef VIDEO_FRAMEBUF_DROP_OLDEST_EN
    logic        d_valid = 1'b0, d_tick = 1'b0;
    logic        d_ready, d_pv;
    logic [0:0]  d_pix;
    logic [1:0]  d_rd, d_wr;
    logic [15:0] d_reps, d_drops;

    video_framebuf #(.NUM_BANKS(3), .SRC_W(8), .SRC_H(4)) d_dut (
        .CLK_40(clk), .reset(reset), .in_valid(d_valid), .in_ready(d_ready),
        .in_data(1'b0), .in_sof(1'b0), .frame_tick(d_tick), .active(1'b0),
        .VGA_x_pos(11'd0), .VGA_y_pos(10'd0), .pix_out(d_pix), .pix_valid(d_pv),
        .rd_bank(d_rd), .wr_bank(d_wr), .frames_repeated(d_reps), .frames_dropped(d_drops)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // One full frame, one beat per cycle; optional tick on the last beat.
    task automatic write_frame(input int px, input int py, input bit tick_last, output bit rdy_ok);
        rdy_ok = 1'b1;
        for (int y = 0; y < 150; y++) begin
            for (int x = 0; x < 200; x++) begin
                if (in_ready !== 1'b1) rdy_ok = 1'b0;
                in_valid   = 1'b1;
                in_data    = (x == px && y == py) ? 1'b1 : 1'b0;
                frame_tick = tick_last && x == 199 && y == 149;
                @(negedge clk);
            end
        end
        in_valid   = 1'b0;
        in_data    = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic probe(input logic [10:0] x, input logic [9:0] y, input logic a,
                         output logic p, output logic v);
        vx = x; vy = y; active = a;
        @(negedge clk);
        @(negedge clk);
        p = pix_out;
        v = pix_valid;
        vx = '0; vy = '0; active = 1'b0;
    endtask

    initial begin
        bit   ok;
        logic p, v;

        // Reset state
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_rd", rd_bank, 0);
        chk("rst_wr", wr_bank, 1);
        chk("rst_rep", reps, 0);
        chk("rst_drop", drops, 0);
        chk("rst_pv", pix_valid, 0);
        chk("rst_pix", pix_out, 0);

        // Frame 1 into bank 1 with pixel (10,5)=1, tick on the final beat
        write_frame(10, 5, 1'b1, ok);
        chk("f1_ready_held", ok, 1);
        chk("f1_rd", rd_bank, 1);
        chk("f1_wr", wr_bank, 0);
        chk("f1_ready", in_ready, 1);
        chk("f1_rep", reps, 0);

        // Exact two-cycle read latency, then x beyond the scaled width
        vx = 11'd43; vy = 10'd22; active = 1'b1;
        @(negedge clk);
        chk("lat_c1_pix", pix_out, 0);
        vx = 11'd800;
        @(negedge clk);
        chk("lat_c2_pix", pix_out, 1);
        chk("lat_c2_pv", pix_valid, 1);
        @(negedge clk);
        chk("x800_pix", pix_out, 0);
        chk("x800_pv", pix_valid, 1);
        active = 1'b0; vx = '0; vy = '0;
        @(negedge clk); @(negedge clk);
        probe(11'd40, 10'd20, 1'b1, p, v);
        chk("p40_20", p, 1);
        probe(11'd39, 10'd22, 1'b1, p, v);
        chk("p39_22", p, 0);
        probe(11'd43, 10'd22, 1'b0, p, v);
        chk("inactive_pix", p, 0);
        chk("inactive_pv", v, 0);
        probe(11'd43, 10'd600, 1'b1, p, v);
        chk("y600_pix", p, 0);

        // Frame 2 into bank 0 with pixel (11,5)=1, then stall with in_valid held
        write_frame(11, 5, 1'b0, ok);
        chk("f2_ready_held", ok, 1);
        in_valid = 1'b1; in_data = 1'b1;
        @(negedge clk);
        chk("stall_ready", in_ready, 0);
        @(negedge clk); @(negedge clk);
        chk("stall_ready2", in_ready, 0);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; in_valid = 1'b0; in_data = 1'b0;
        chk("tick_ready", in_ready, 1);
        chk("tick_rd", rd_bank, 0);
        chk("tick_wr", wr_bank, 1);
        chk("tick_rep", reps, 0);
        probe(11'd47, 10'd23, 1'b1, p, v);
        chk("b0_p11_5", p, 1);
        probe(11'd43, 10'd22, 1'b1, p, v);
        chk("b0_p10_5", p, 0);
        probe(11'd0, 10'd0, 1'b1, p, v);
        chk("b0_stall_nowrite", p, 0);

        // Reset keeps RAM; then three ticks with nothing complete
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        probe(11'd44, 10'd20, 1'b1, p, v);
        chk("ram_kept", p, 1);
        repeat (3) begin
            frame_tick = 1'b1;
            @(negedge clk);
        end
        frame_tick = 1'b0;
        @(negedge clk);
        chk("rep3", reps, 3);
        chk("rep3_rd", rd_bank, 0);

        // 100 beats then reset mid-frame
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b100_wx", dut.wx, 100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_wx", dut.wx, 0);
        chk("mid_wy", dut.wy, 0);
        chk("mid_rd", rd_bank, 0);
        chk("mid_wr", wr_bank, 1);
        chk("mid_rep", reps, 0);
        chk("mid_drop", drops, 0);
        chk("mid_ready", in_ready, 1);

        // Start-of-frame beat restarts at the origin
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_sof = 1'b1;
        @(negedge clk);
        in_sof = 1'b0; in_valid = 1'b0;
        chk("sof_wx", dut.wx, 1);
        chk("sof_wy", dut.wy, 0);

`ifdef VIDEO_FRAMEBUF_DROP_OLDEST_EN
        // Two small frames with no tick on a 3-bank instance
        ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (d_ready !== 1'b1) ok = 1'b0;
            d_valid = 1'b1;
            @(negedge clk);
        end
        d_valid = 1'b0;
        @(negedge clk);
        chk("drop_ready_held", ok, 1);
        chk("drop_ready", d_ready, 1);
        chk("drop_cnt", d_drops, 1);
        chk("drop_wr", d_wr, 1);
        chk("drop_rep", d_reps, 0);
        d_tick = 1'b1;
        @(negedge clk);
        d_tick = 1'b0;
        chk("drop_tick_rd", d_rd, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_framebuf.md
VIDEO_FRAMEBUF -- requirements
Module: video_framebuf

Interface
REQ-001 Parameters SHALL be: NUM_BANKS, default 2, bank count (2..4); BPP, default 1, bits per pixel (1..8); SCALE, default 4, display upscale factor (power of 2); SRC_W, default 200, source width; SRC_H, default 150, source height.
REQ-002 Ports (name direction width meaning) SHALL be:
- CLK_40  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  write pixel valid.
- in_ready  out  1  write pixel accepted when in_valid is also high.
- in_data  in  BPP  write pixel value.
- in_sof  in  1  qualifies the beat as the first pixel of a frame.
- frame_tick  in  1  one-cycle pulse at the start of VGA vertical blank.
- active  in  1  VGA active-video flag.
- VGA_x_pos  in  11  scan x position.
- VGA_y_pos  in  10  scan y position.
- pix_out  out  BPP  display pixel.
- pix_valid  out  1  active delayed to align with pix_out.
- rd_bank  out  clog2(NUM_BANKS)  bank being displayed.
- wr_bank  out  clog2(NUM_BANKS)  bank being written.
- frames_repeated  out  16  saturating count of ticks with no new frame.
- frames_dropped  out  16  saturating count of discarded complete frames.

Function
REQ-003 Each bank SHALL be in exactly one of FREE, WRITING, FULL or DISPLAY; exactly one bank SHALL be DISPLAY at all times, and at most one bank SHALL be WRITING.
REQ-004 Every accepted beat (in_valid && in_ready) SHALL write in_data at the write address (wx, wy) of the WRITING bank, then advance wx; when wx = SRC_W-1, wx SHALL wrap to 0 and wy SHALL increment.
REQ-005 An accepted beat with in_sof = 1 SHALL be written at (0,0), continue from (1,0), and discard the partial frame without changing bank state.
REQ-006 The accepted beat at (SRC_W-1, SRC_H-1) SHALL move the WRITING bank to FULL, reset (wx, wy) to (0,0), and append the bank to a FIFO-ordered FULL list.
REQ-007 If a FREE bank exists, the lowest-index FREE bank SHALL become WRITING on the next cycle; otherwise in_ready SHALL be 0 until a bank is allocated.
REQ-008 in_ready SHALL be 1 if and only if a WRITING bank exists.
REQ-009 On frame_tick with a non-empty FULL list:
- the oldest FULL bank SHALL become DISPLAY;
- the previous DISPLAY bank SHALL become FREE;
- rd_bank SHALL update on the following cycle.
REQ-010 On frame_tick with an empty FULL list, DISPLAY SHALL be unchanged and frames_repeated SHALL increment, saturating at 0xFFFF.
REQ-011 When frame completion and frame_tick occur in the same cycle, the just-completed bank SHALL be eligible for that tick.
REQ-012 Read address SHALL be (VGA_x_pos / SCALE, VGA_y_pos / SCALE), implemented as a right shift by log2(SCALE).
REQ-013 pix_out and pix_valid SHALL appear exactly 2 cycles after VGA_x_pos, VGA_y_pos and active.
REQ-014 pix_out SHALL be 0 when:
- active was 0; or
- VGA_x_pos >= SRC_W*SCALE; or
- VGA_y_pos >= SRC_H*SCALE.
REQ-015 The DISPLAY bank and the WRITING bank SHALL never be the same bank.
REQ-016 Elaboration SHALL fail if SCALE is not a power of 2 or NUM_BANKS is outside 2..4.

Reset
REQ-017 On reset:
- bank 0 SHALL be DISPLAY, bank 1 WRITING, all others FREE;
- rd_bank = 0 and wr_bank = 1;
- (wx, wy) = (0,0);
- the FULL list SHALL be empty;
- both counters, pix_out, pix_valid and the read pipeline SHALL be 0;
- in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-018 Reset asserted mid-frame SHALL discard all partial and FULL frames; RAM contents SHALL NOT be cleared.

Configuration
REQ-019 With VIDEO_FRAMEBUF_DROP_OLDEST_EN defined, frame completion with no FREE bank SHALL:
- reclaim the oldest FULL bank (or the just-completed bank if it is the only FULL bank) as WRITING in the same cycle;
- increment frames_dropped;
- keep in_ready at 1.
REQ-020 Without VIDEO_FRAMEBUF_DROP_OLDEST_EN, the writer SHALL stall per REQ-007 and frames_dropped SHALL be tied to 0.

Structure
REQ-021 The bank-state enumeration and the default SRC_W, SRC_H and SCALE constants SHALL live in the shared package video_pkg.
REQ-022 Each bank SHALL be one instance of the sub-module framebuf_bank: SRC_W*SRC_H x BPP, one synchronous write port and one registered read port.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Defaults: write 30000 beats, then pulse frame_tick -> rd_bank = 1, wr_bank = 0, in_ready stays 1.
- Defaults: write 30000 beats and hold in_valid, no tick -> in_ready = 0 on the next cycle; after a tick, in_ready = 1 within 2 cycles.
- With DROP_OLDEST_EN: write 2 frames with no tick -> frames_dropped = 1 and in_ready is never 0.
- Three frame_ticks with no writes -> frames_repeated = 3 and rd_bank = 0.
- Pixel (10,5) = 1, SCALE = 4, VGA_x_pos = 43, VGA_y_pos = 22, active = 1 -> pix_out = 1 two cycles later; VGA_x_pos = 800 -> pix_out = 0.
- Reset after 100 beats -> wx = 0, wy = 0, rd_bank = 0, wr_bank = 1, both counters 0.
